// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage: operand select codes and
// the packed control bundle carried alongside each instruction.
package id_ex_stage_pkg;

    localparam logic [1:0] SEL_REG = 2'b00;  // register-file (or bypassed) data
    localparam logic [1:0] SEL_EXM = 2'b01;  // forward from EX/MEM
    localparam logic [1:0] SEL_MWB = 2'b10;  // forward from MEM/WB
    localparam logic [1:0] SEL_IMM = 2'b11;  // immediate operand

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand select resolver. Looks at the instruction currently in EX (which
// will be in EX/MEM when the new instruction executes) and the one in MEM
// (which will be in MEM/WB) and picks the forwarding source for one operand.
import id_ex_stage_pkg::*;

module fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_imm,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        sel
);

    // Priority: immediate, r0 never forwarded, nearest producer first.
    always_comb begin
        sel = SEL_REG;
        if (use_imm) begin
            sel = SEL_IMM;
        end else if (src == {REG_AW{1'b0}}) begin
            sel = SEL_REG;
        end else if (ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == src)) begin
            sel = SEL_EXM;
        end else if (mem_reg_write && (mem_rd == src)) begin
            sel = SEL_MWB;
        end else begin
            sel = SEL_REG;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, resolves the
// EX operand selects a cycle early, inserts load-use bubbles and obeys
// flush/hold from the rest of the pipeline.
import id_ex_stage_pkg::*;

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic [1:0]        ex_sel_st,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid_r;
    logic [OP_W-1:0]   ex_alu_op_r;
    logic [DATA_W-1:0] ex_rs_data_r;
    logic [DATA_W-1:0] ex_rt_data_r;
    logic [DATA_W-1:0] ex_imm_r;
    logic [REG_AW-1:0] ex_rd_r;
    logic [1:0]        ex_sel_a_r;
    logic [1:0]        ex_sel_b_r;
    logic [1:0]        ex_sel_st_r;
    ctrl_t             ex_ctrl_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    logic              hazard_s;
    logic [1:0]        sel_a_s;
    logic [1:0]        sel_b_s;
    logic [1:0]        sel_st_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    ctrl_t             id_ctrl_s;

    assign id_ctrl_s = '{reg_write: id_reg_write, mem_read: id_mem_read,
                         mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};

    fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
        .src(id_rs_addr), .use_imm(1'b0),
        .ex_valid(ex_valid_r), .ex_reg_write(ex_ctrl_r.reg_write),
        .ex_mem_read(ex_ctrl_r.mem_read), .ex_rd(ex_rd_r),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .sel(sel_a_s)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
        .src(id_rt_addr), .use_imm(id_use_imm),
        .ex_valid(ex_valid_r), .ex_reg_write(ex_ctrl_r.reg_write),
        .ex_mem_read(ex_ctrl_r.mem_read), .ex_rd(ex_rd_r),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .sel(sel_b_s)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_sel_st (
        .src(id_rt_addr), .use_imm(1'b0),
        .ex_valid(ex_valid_r), .ex_reg_write(ex_ctrl_r.reg_write),
        .ex_mem_read(ex_ctrl_r.mem_read), .ex_rd(ex_rd_r),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .sel(sel_st_s)
    );

    // Load-use detection: a load in EX whose result ID needs next cycle.
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid && ex_valid_r && ex_ctrl_r.mem_read && (ex_rd_r != {REG_AW{1'b0}})) begin
            if ((ex_rd_r == id_rs_addr) || (id_uses_rt && (ex_rd_r == id_rt_addr))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Write-through bypass: a same-cycle register-file write supersedes stale read data.
    always_comb begin
        rs_data_s = id_rs_data;
        rt_data_s = id_rt_data;
        if (wb_reg_write && (wb_rd != {REG_AW{1'b0}})) begin
            if (wb_rd == id_rs_addr) begin
                rs_data_s = wb_data;
            end else begin
                rs_data_s = id_rs_data;
            end
            if (wb_rd == id_rt_addr) begin
                rt_data_s = wb_data;
            end else begin
                rt_data_s = id_rt_data;
            end
        end else begin
            rs_data_s = id_rs_data;
            rt_data_s = id_rt_data;
        end
    end

    // A flushed instruction must not also freeze the front end.
    assign stall_id = hazard_s & ~flush;

    // Pipeline register update: rst > flush > hold > bubble > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r   <= 1'b0;
            ex_alu_op_r  <= {OP_W{1'b0}};
            ex_rs_data_r <= {DATA_W{1'b0}};
            ex_rt_data_r <= {DATA_W{1'b0}};
            ex_imm_r     <= {DATA_W{1'b0}};
            ex_rd_r      <= {REG_AW{1'b0}};
            ex_sel_a_r   <= SEL_REG;
            ex_sel_b_r   <= SEL_REG;
            ex_sel_st_r  <= SEL_REG;
            ex_ctrl_r    <= ctrl_t'(4'b0000);
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= ctrl_t'(4'b0000);
        end else if (hold) begin
            ex_valid_r <= ex_valid_r;
            ex_ctrl_r  <= ex_ctrl_r;
        end else if (hazard_s) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= ctrl_t'(4'b0000);
            if (bubble_cnt_r != {CNT_W{1'b1}}) begin
                bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end else begin
            ex_valid_r   <= id_valid;
            ex_alu_op_r  <= id_alu_op;
            ex_rs_data_r <= rs_data_s;
            ex_rt_data_r <= rt_data_s;
            ex_imm_r     <= id_imm;
            ex_rd_r      <= id_rd_addr;
            ex_sel_a_r   <= sel_a_s;
            ex_sel_b_r   <= sel_b_s;
            ex_sel_st_r  <= sel_st_s;
            ex_ctrl_r    <= id_ctrl_s;
        end
    end

    assign ex_valid      = ex_valid_r;
    assign ex_alu_op     = ex_alu_op_r;
    assign ex_rs_data    = ex_rs_data_r;
    assign ex_rt_data    = ex_rt_data_r;
    assign ex_imm        = ex_imm_r;
    assign ex_rd         = ex_rd_r;
    assign ex_sel_a      = ex_sel_a_r;
    assign ex_sel_b      = ex_sel_b_r;
    assign ex_sel_st     = ex_sel_st_r;
    assign ex_reg_write  = ex_ctrl_r.reg_write;
    assign ex_mem_read   = ex_ctrl_r.mem_read;
    assign ex_mem_write  = ex_ctrl_r.mem_write;
    assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
    assign bubble_cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. The bubble counter is narrowed to 8 bits
// so saturation can be reached in a few hundred cycles.
module tb_id_ex_stage;

    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        rst, flush, hold, id_valid;
    logic [5:0]  id_alu_op;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_uses_rt, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] wb_data;
    logic        stall_id, ex_valid;
    logic [5:0]  ex_alu_op;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_sel_a, ex_sel_b, ex_sel_st;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [CW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .OP_W(6), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .ex_sel_st(ex_sel_st),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .bubble_cnt(bubble_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; hold = 1'b0; id_valid = 1'b0; id_alu_op = 6'd0;
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rd_addr = 5'd0;
        id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
        id_use_imm = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        mem_reg_write = 1'b0; mem_rd = 5'd0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    // Present one instruction in ID: op, rs, rt, rd, rs data, rt data, imm, use_imm, uses_rt, rw, mr.
    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic ui, input logic ur,
                          input logic rw, input logic mr);
        id_valid = 1'b1; id_alu_op = op; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui; id_uses_rt = ur;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0; id_mem_to_reg = mr;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}); end
        checks++; if ({ex_sel_a, ex_sel_b, ex_sel_st} !== 6'b000000) begin
            errors++; $display("FAIL reset_sel got %b want 000000", {ex_sel_a, ex_sel_b, ex_sel_st}); end
        checks++; if ({ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_alu_op} !== 107'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_alu_op}); end
        checks++; if (bubble_cnt !== 8'd0 || stall_id !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_stall got %0d/%b want 0/0", bubble_cnt, stall_id); end
        rst = 1'b0;
    endtask

    // add r3,r1,r2 ; sub r4,r3,r5
    task automatic test_fwd_exm();
        idle();
        set_id(6'd1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(6'd2, 5'd3, 5'd5, 5'd4, 32'h0, 32'h55, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (stall_id !== 1'b0) begin
            errors++; $display("FAIL exm_stall got %b want 0", stall_id); end
        step();
        checks++; if (ex_sel_a !== 2'b01 || ex_sel_b !== 2'b00) begin
            errors++; $display("FAIL exm_sel got a=%b b=%b want a=01 b=00", ex_sel_a, ex_sel_b); end
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_alu_op !== 6'd2 || ex_rt_data !== 32'h55) begin
            errors++; $display("FAIL exm_capture got v=%b rd=%0d op=%0d rt=%h want 1/4/2/55", ex_valid, ex_rd, ex_alu_op, ex_rt_data); end
    endtask

    // lw r6,0(r1) ; add r7,r6,r2
    task automatic test_load_use();
        idle();
        set_id(6'd3, 5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(6'd1, 5'd6, 5'd2, 5'd7, 32'h0, 32'h22, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (stall_id !== 1'b1) begin
            errors++; $display("FAIL lu_stall got %b want 1", stall_id); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || bubble_cnt !== 8'd1) begin
            errors++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b cnt=%0d want 0/0/0/1", ex_valid, ex_reg_write, ex_mem_read, bubble_cnt); end
        mem_reg_write = 1'b1; mem_rd = 5'd6;
        #1;
        checks++; if (stall_id !== 1'b0) begin
            errors++; $display("FAIL lu_stall_release got %b want 0", stall_id); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_sel_a !== 2'b10 || ex_sel_b !== 2'b00 || ex_rd !== 5'd7) begin
            errors++; $display("FAIL lu_enter got v=%b a=%b b=%b rd=%0d want 1/10/00/7", ex_valid, ex_sel_a, ex_sel_b, ex_rd); end
        checks++; if (bubble_cnt !== 8'd1) begin
            errors++; $display("FAIL lu_cnt_once got %0d want 1", bubble_cnt); end
    endtask

    // Two writers of r8 in flight; consumer must take the younger (EX/MEM) one.
    task automatic test_priority();
        idle();
        set_id(6'd1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(6'd1, 5'd3, 5'd4, 5'd8, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        mem_reg_write = 1'b1; mem_rd = 5'd8;
        set_id(6'd4, 5'd8, 5'd8, 5'd10, 32'h0, 32'h0, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (ex_sel_a !== 2'b01 || ex_sel_b !== 2'b11 || ex_sel_st !== 2'b01) begin
            errors++; $display("FAIL prio_sel got a=%b b=%b st=%b want 01/11/01", ex_sel_a, ex_sel_b, ex_sel_st); end
        // EX now holds a non-writer; MEM still writes r8 -> MEM/WB source.
        set_id(6'd5, 5'd8, 5'd8, 5'd11, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (ex_sel_a !== 2'b10 || ex_sel_b !== 2'b10 || ex_sel_st !== 2'b10) begin
            errors++; $display("FAIL mwb_sel got a=%b b=%b st=%b want 10/10/10", ex_sel_a, ex_sel_b, ex_sel_st); end
    endtask

    task automatic test_bypass();
        idle();
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
        set_id(6'd1, 5'd9, 5'd9, 5'd12, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (ex_rs_data !== 32'hDEADBEEF || ex_rt_data !== 32'hDEADBEEF || ex_sel_a !== 2'b00) begin
            errors++; $display("FAIL bypass got rs=%h rt=%h a=%b want deadbeef/deadbeef/00", ex_rs_data, ex_rt_data, ex_sel_a); end
        wb_rd = 5'd13;
        set_id(6'd1, 5'd9, 5'd13, 5'd14, 32'h1234, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (ex_rs_data !== 32'h1234 || ex_rt_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_sel got rs=%h rt=%h want 1234/deadbeef", ex_rs_data, ex_rt_data); end
    endtask

    task automatic test_r0();
        idle();
        set_id(6'd1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        mem_reg_write = 1'b1; mem_rd = 5'd0;
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF0000;
        set_id(6'd1, 5'd0, 5'd0, 5'd15, 32'h5, 32'h6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (ex_sel_a !== 2'b00 || ex_sel_b !== 2'b00 || ex_sel_st !== 2'b00) begin
            errors++; $display("FAIL r0_sel got a=%b b=%b st=%b want 00/00/00", ex_sel_a, ex_sel_b, ex_sel_st); end
        checks++; if (ex_rs_data !== 32'h5 || ex_rt_data !== 32'h6) begin
            errors++; $display("FAIL r0_bypass got rs=%h rt=%h want 5/6", ex_rs_data, ex_rt_data); end
        idle();
        set_id(6'd3, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(6'd1, 5'd0, 5'd0, 5'd16, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (stall_id !== 1'b0) begin
            errors++; $display("FAIL r0_load_stall got %b want 0", stall_id); end
        step();
    endtask

    task automatic test_flush_hold();
        idle();
        set_id(6'd3, 5'd1, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(6'd1, 5'd6, 5'd2, 5'd7, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        flush = 1'b1; hold = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b0) begin
            errors++; $display("FAIL flush_stall got %b want 0", stall_id); end
        step();
        checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'b00000 || bubble_cnt !== 8'd1) begin
            errors++; $display("FAIL flush_hold got ctrl=%b cnt=%0d want 00000/1", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, bubble_cnt); end
        flush = 1'b0; hold = 1'b0;
        set_id(6'd5, 5'd12, 5'd13, 5'd11, 32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        hold = 1'b1;
        set_id(6'd9, 5'd20, 5'd21, 5'd22, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        step();
        checks++; if (ex_valid !== 1'b1 || ex_alu_op !== 6'd5 || ex_rd !== 5'd11 || ex_rs_data !== 32'hAAAA ||
                      ex_rt_data !== 32'hBBBB || ex_imm !== 32'hCCCC) begin
            errors++; $display("FAIL hold_data got v=%b op=%0d rd=%0d rs=%h rt=%h imm=%h want 1/5/11/aaaa/bbbb/cccc",
                               ex_valid, ex_alu_op, ex_rd, ex_rs_data, ex_rt_data, ex_imm); end
        checks++; if ({ex_reg_write, ex_mem_read, ex_sel_a, ex_sel_b} !== 6'b100000 || bubble_cnt !== 8'd1) begin
            errors++; $display("FAIL hold_ctrl got %b cnt=%0d want 100000/1", {ex_reg_write, ex_mem_read, ex_sel_a, ex_sel_b}, bubble_cnt); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || ex_rs_data !== 32'd0 || bubble_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_mid got v=%b rw=%b rd=%0d rs=%h cnt=%0d want all 0", ex_valid, ex_reg_write, ex_rd, ex_rs_data, bubble_cnt); end
        rst = 1'b0;
    endtask

    // A self-dependent load (lw r6,0(r6)) repeated: one bubble every two cycles.
    task automatic test_saturate();
        idle();
        set_id(6'd3, 5'd6, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            step();
            step();
            if (i == 254) begin
                checks++; if (bubble_cnt !== 8'd255) begin
                    errors++; $display("FAIL sat_reach got %0d want 255", bubble_cnt); end
            end
        end
        checks++; if (bubble_cnt !== 8'hFF) begin
            errors++; $display("FAIL sat_hold got %0d want 255", bubble_cnt); end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_fwd_exm();
        test_load_use();
        test_priority();
        test_bypass();
        test_r0();
        test_flush_hold();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register feeding the execute stage (ALU plus the operand 4:1 muxes).
- Captures the decoded instruction and its operands.
- Resolves the forwarding mux selects one cycle ahead.
- Detects load-use hazards and inserts bubbles.
- Honours the flush (taken branch/jump) and hold (downstream memory wait) controls.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width
OP_W, 6, alu_op width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  taken branch/jump: kill the instruction entering EX
hold  in  1  downstream stall: freeze the register
id_valid  in  1  ID holds a real instruction
id_alu_op  in  OP_W  decoded ALU operation
id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW each  source/destination registers
id_rs_data, id_rt_data  in  DATA_W each  register-file read data
id_imm  in  DATA_W  extended immediate
id_use_imm  in  1  ALU operand B is the immediate
id_uses_rt  in  1  instruction reads rt (ALU or store data)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
mem_reg_write  in  1  instruction now in MEM writes a register
mem_rd  in  REG_AW  its destination
wb_reg_write  in  1  register-file write this cycle
wb_rd  in  REG_AW  write address
wb_data  in  DATA_W  write data
stall_id  out  1  combinational; freeze PC and IF/ID
ex_valid  out  1  EX holds a real instruction
ex_alu_op  out  OP_W
ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each
ex_rd  out  REG_AW
ex_sel_a  out  2  00 reg, 01 EX/MEM fwd, 10 MEM/WB fwd
ex_sel_b  out  2  same encoding; 11 = immediate
ex_sel_st  out  2  store-data select, same as sel_a encoding
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each
bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset: all outputs 0, including valid, selects and bubble_cnt. stall_id follows from ex_valid=0, so it is 0.
- Register update priority each edge: rst > flush > hold > bubble > capture.
- Flush: ex_valid and all four control bits cleared. Data fields don't-care. Flush wins over hold.
- Hold: every register keeps its value. bubble_cnt does not increment.
- Load-use hazard (combinational), when all of these hold:
  - id_valid, ex_valid and ex_mem_read are 1
  - ex_rd != 0
  - ex_rd == id_rs_addr, or (id_uses_rt and ex_rd == id_rt_addr)
- On a hazard:
  - stall_id = 1, forced 0 while flush is asserted.
  - Next edge (no flush/hold): bubble captured, i.e. valid and controls 0.
  - bubble_cnt increments, saturating at all-ones.
- Capture: all id_* fields move to ex_*, with ex_valid = id_valid.
- Selects are computed at capture. The EX-stage instruction becomes EX/MEM next cycle; the MEM instruction becomes MEM/WB.
- sel_a:
  - rs = 0 gives 00.
  - Else 01 if ex_valid, ex_reg_write, !ex_mem_read and ex_rd == rs.
  - Else 10 if mem_reg_write and mem_rd == rs.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
- sel_b: 11 if id_use_imm, otherwise same rule on rt.
- sel_st: same rule on rt, ignoring id_use_imm.
- Write-through bypass at capture: if wb_reg_write, wb_rd != 0 and wb_rd matches rs (or rt), the captured data is wb_data instead of the register-file read data.
- Destination 0: never a forwarding source and never triggers a hazard.
- Latency: one cycle ID to EX. A bubble adds exactly one cycle per load-use pair.

Decomposition:
- Shared pipeline package holds:
  - localparams SEL_REG=2'b00, SEL_EXM=2'b01, SEL_MWB=2'b10, SEL_IMM=2'b11
  - a packed control-bundle struct {reg_write, mem_read, mem_write, mem_to_reg}
- One sub-module, fwd_sel: pure combinational select resolver. It is instantiated three times (a, b, store).
- Hazard detect and the registers stay in the top.

Test Plan:
1. add r3,r1,r2 then sub r4,r3,r5, no stalls -> second instruction's ex_sel_a = 01, ex_sel_b = 00, stall_id = 0.
2. lw r6,0(r1) then add r7,r6,r2 -> stall_id = 1 for one cycle; next EX is a bubble (ex_valid = 0); bubble_cnt 0 to 1; the add then enters with ex_sel_a = 10.
3. Writer to r8 two instructions ahead while the EX instruction also writes r8; consumer reads r8 -> ex_sel_a = 01, since EX/MEM has priority.
4. wb_reg_write = 1, wb_rd = 9, wb_data = 0xDEADBEEF while ID reads r9 with stale data 0x0 -> ex_rs_data = 0xDEADBEEF, ex_sel_a = 00.
5. flush and hold together during a hazard -> ex_valid = 0, controls 0, bubble_cnt unchanged. Next cycle hold alone -> all ex_* stable.
6. rst asserted mid-stream with ex_valid = 1 -> next edge all outputs 0. Also: 65535 hazards then one more -> bubble_cnt stays 0xFFFF. Also: writes to r0 are never forwarded.
